// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and imem fetch engine with a (pc, inst) FIFO; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        trap_misalign
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif
  state_t state;
  logic [31:0] fetch_pc, ret_pc, new_pc, head_pc, head_inst;
  logic [OW-1:0] outstanding, discard_cnt;
  logic [CW-1:0] count, cnt_after_pop;
  logic [AW-1:0] rd_ptr, wr_ptr, nxt_rd;
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic redirect, hs, push, pop, credit, load_head, unused_addr_lsb;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign redirect = redirect_valid && state != TRAP;
  assign misalign = redirect_addr[1];
`else
  assign redirect = redirect_valid;
  assign trap_misalign = 1'b0;
`endif
  assign unused_addr_lsb = ^redirect_addr[1:0];
  assign new_pc = {redirect_addr[31:2], 2'b00};
  assign credit = 32'(outstanding - discard_cnt) + 32'(count) < 32'(FIFO_DEPTH);
  assign imem_req_valid = state == RUN && !redirect_valid && 32'(outstanding) < 32'(MAX_OUTSTANDING) && credit;
  assign imem_req_addr = fetch_pc;
  assign hs = imem_req_valid && imem_req_ready;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign push = imem_rsp_valid && discard_cnt == '0 && !redirect;
  assign cnt_after_pop = count - CW'(pop);
  assign nxt_rd = rd_ptr + AW'(pop);
  assign head_pc = cnt_after_pop == '0 ? ret_pc : fifo_pc[nxt_rd];
  assign head_inst = cnt_after_pop == '0 ? imem_rsp_data : fifo_inst[nxt_rd];
  assign load_head = !redirect && (cnt_after_pop != '0 || push);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      ret_pc <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      out_pc <= '0;
      out_inst <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_misalign <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + OW'(hs) - OW'(imem_rsp_valid);
      if (load_head) begin
        out_pc <= head_pc;
        out_inst <= head_inst;
      end
      if (redirect) begin
        discard_cnt <= outstanding - OW'(imem_rsp_valid);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign) begin
          state <= TRAP;
          trap_misalign <= 1'b1;
        end else
`endif
        begin
          state <= RUN;
          fetch_pc <= new_pc;
          ret_pc <= new_pc;
        end
      end else begin
        if (state == BOOT) state <= RUN;
        if (imem_rsp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
        if (hs) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          ret_pc <= ret_pc + 32'd4;
        end
        if (pop) rd_ptr <= nxt_rd;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr] <= ret_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (count != CW'(FIFO_DEPTH));
  end
endmodule
